// File: rtl/pipe_out_pkg.sv
// Shared types and defaults for the pipe-out buffer slice.
package pipe_out_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned UflowCntWidth = 16;

  typedef logic [DataWidth-1:0]     data_t;
  typedef logic [UflowCntWidth-1:0] uflow_cnt_t;

  localparam data_t FillWordDefault = 32'hFFFF_FFFF;

  // Saturating increment for the empty-read counter.
  function automatic uflow_cnt_t uflow_sat_inc(input uflow_cnt_t v);
    return (v == '1) ? v : v + uflow_cnt_t'(1);
  endfunction

endpackage

// File: rtl/pipe_out_buffer_if.sv
// Handshake bundle between user write logic / pipe endpoint and the buffer.
interface pipe_out_buffer_if
  import pipe_out_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) ();

  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  data_t             din;
  logic              din_valid;
  logic              din_ready;
  logic              ep_read;
  data_t             ep_datain;
  logic              ep_blockstrobe_ready;
  logic [LevelW-1:0] level;
  logic              underflow;
  uflow_cnt_t        underflow_count;

  // Producer/endpoint side.
  modport master (
    output din, din_valid, ep_read,
    input  din_ready, ep_datain, ep_blockstrobe_ready, level, underflow, underflow_count
  );

  // Buffer side.
  modport slave (
    input  din, din_valid, ep_read,
    output din_ready, ep_datain, ep_blockstrobe_ready, level, underflow, underflow_count
  );

endinterface

// File: rtl/pipe_out_mem.sv
// DEPTH x 32 storage: synchronous write, asynchronous read (distributed RAM style).
module pipe_out_mem
  import pipe_out_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  data_t            wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output data_t            rdata_o
);

  data_t mem_q [DEPTH];

  // Write port; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_out_buffer.sv
// First-word-fall-through output buffer feeding a pipe endpoint, with
// block-ready indication and sticky/counting underflow detection.
module pipe_out_buffer
  import pipe_out_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned BLOCK_WORDS = 256,
  parameter data_t       FILL_WORD   = FillWordDefault
) (
  input logic               okClk,
  input logic               reset,
  pipe_out_buffer_if.slave  bus
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned LevelW = AddrW + 1;

  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              underflow_q, underflow_d;
  uflow_cnt_t        uflow_cnt_q, uflow_cnt_d;
  logic              blk_rdy_q, blk_rdy_d;

  logic  full, empty, push, pop, uflow_evt;
  data_t mem_rdata;

  assign full      = (level_q == LevelW'(DEPTH));
  assign empty     = (level_q == '0);
  assign push      = bus.din_valid && !full && !reset;
  assign pop       = bus.ep_read && !empty && !reset;
  assign uflow_evt = bus.ep_read && empty && !reset;

  pipe_out_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (okClk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.din),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Outputs are forced to their reset-state values while reset is held, even
  // before the registers have been cleared by the first reset edge.
  assign bus.din_ready            = reset || !full;
  assign bus.ep_datain            = (reset || empty) ? FILL_WORD : mem_rdata;
  assign bus.level                = level_q;
  assign bus.underflow            = underflow_q;
  assign bus.underflow_count      = uflow_cnt_q;
  assign bus.ep_blockstrobe_ready = blk_rdy_q;

  // Next-state for pointers, occupancy, underflow tracking and block-ready.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;
    uflow_cnt_d = uflow_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
    if (uflow_evt) begin
      underflow_d = 1'b1;
      uflow_cnt_d = uflow_sat_inc(uflow_cnt_q);
    end
    // Registered from the settled level, so it trails level by one cycle.
    blk_rdy_d = (level_q >= LevelW'(BLOCK_WORDS));
  end

  // State registers with synchronous reset.
  always_ff @(posedge okClk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      uflow_cnt_q <= '0;
      blk_rdy_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
      uflow_cnt_q <= uflow_cnt_d;
      blk_rdy_q   <= blk_rdy_d;
    end
  end

endmodule

// File: tb/tb_pipe_out_buffer.sv
// Scoreboard bench for pipe_out_buffer.
module tb_pipe_out_buffer;
  import pipe_out_pkg::*;

  localparam int unsigned Depth      = 512;
  localparam int unsigned BlockWords = 256;
  localparam data_t       Fill       = 32'hFFFF_FFFF;

  logic clk;
  logic rst;

  pipe_out_buffer_if #(.DEPTH(Depth)) bus ();

  pipe_out_buffer #(
    .DEPTH       (Depth),
    .BLOCK_WORDS (BlockWords),
    .FILL_WORD   (Fill)
  ) dut (
    .okClk (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state.
  data_t exp_q[$];
  int    m_level;
  logic  m_uflow;
  int    m_ucnt;
  logic  m_bs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model on the edge.
  task automatic step(input data_t d, input logic v, input logic r);
    logic m_push, m_pop, m_uev;
    bus.din       = d;
    bus.din_valid = v;
    bus.ep_read   = r;
    @(negedge clk);
    check("ep_datain", bus.ep_datain, (exp_q.size() == 0) ? Fill : exp_q[0]);
    check("din_ready", {31'b0, bus.din_ready}, {31'b0, m_level != int'(Depth)});
    check("level", 32'(bus.level), m_level);
    check("underflow", {31'b0, bus.underflow}, {31'b0, m_uflow});
    check("underflow_count", 32'(bus.underflow_count), m_ucnt);
    check("blockstrobe", {31'b0, bus.ep_blockstrobe_ready}, {31'b0, m_bs});
    m_push = v && (m_level != int'(Depth));
    m_pop  = r && (m_level != 0);
    m_uev  = r && (m_level == 0);
    @(posedge clk);
    if (m_pop) void'(exp_q.pop_front());
    if (m_push) exp_q.push_back(d);
    m_bs    = (m_level >= int'(BlockWords));
    m_level = m_level + int'(m_push) - int'(m_pop);
    if (m_uev) begin
      m_uflow = 1'b1;
      if (m_ucnt != 16'hFFFF) m_ucnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.din       = 32'hDEAD_BEEF;
    bus.din_valid = 1'b1;
    bus.ep_read   = 1'b1;
    @(negedge clk);
    check("rst_din_ready", {31'b0, bus.din_ready}, 32'd1);
    check("rst_ep_datain", bus.ep_datain, Fill);
    @(posedge clk);
    exp_q.delete();
    m_level = 0;
    m_uflow = 1'b0;
    m_ucnt  = 0;
    m_bs    = 1'b0;
    #1;
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    bus.ep_read   = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.ep_read   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    step('0, 1'b0, 1'b0);
    check("reset_level", 32'(bus.level), 32'd0);

    // Four words in, four out, then fill word.
    for (int i = 1; i <= 4; i++) step(data_t'(i), 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check("fwft_word", bus.ep_datain, data_t'(i));
      step('0, 1'b0, 1'b1);
    end
    step('0, 1'b0, 1'b0);
    check("drain_fill", bus.ep_datain, Fill);
    check("drain_level", 32'(bus.level), 32'd0);
    check("drain_uflow", {31'b0, bus.underflow}, 32'd0);

    // Three empty reads.
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("uflow_flag", {31'b0, bus.underflow}, 32'd1);
    check("uflow_cnt3", 32'(bus.underflow_count), 32'd3);
    check("uflow_level", 32'(bus.level), 32'd0);

    // Push while reading empty: stored, not popped, counts as underflow.
    step(32'h0000_5A5A, 1'b1, 1'b1);
    step('0, 1'b0, 1'b0);
    check("pushrd_level", 32'(bus.level), 32'd1);
    check("pushrd_cnt", 32'(bus.underflow_count), 32'd4);
    check("pushrd_head", bus.ep_datain, 32'h0000_5A5A);
    step('0, 1'b0, 1'b1);

    // Block-ready threshold.
    do_reset();
    for (int i = 0; i < int'(BlockWords) - 1; i++) step($urandom, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    check("bs_below", {31'b0, bus.ep_blockstrobe_ready}, 32'd0);
    step(32'h1234_5678, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    check("bs_at", {31'b0, bus.ep_blockstrobe_ready}, 32'd1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    check("bs_after_pop", {31'b0, bus.ep_blockstrobe_ready}, 32'd0);

    // Fill to the brim with din_valid held, one extra word offered.
    while (m_level < int'(Depth)) step($urandom, 1'b1, 1'b0);
    step(32'hBAD0_BAD0, 1'b1, 1'b0);
    check("full_level", 32'(bus.level), Depth);
    check("full_ready", {31'b0, bus.din_ready}, 32'd0);

    // Full: push + read together -> pop only.
    step(32'hC0FF_EE00, 1'b1, 1'b1);
    check("fullrw_level", 32'(bus.level), Depth - 1);
    check("fullrw_ready", {31'b0, bus.din_ready}, 32'd1);

    // Randomised traffic then full drain.
    for (int i = 0; i < 1500; i++) begin
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    while (m_level > 0) step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("final_level", 32'(bus.level), 32'd0);

    // Reset mid-stream discards contents.
    for (int i = 0; i < 10; i++) step(32'h100 + 32'(i), 1'b1, 1'b0);
    do_reset();
    step(32'h0000_00AB, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    check("mid_rst_level", 32'(bus.level), 32'd1);
    check("mid_rst_head", bus.ep_datain, 32'h0000_00AB);
    check("mid_rst_cnt", 32'(bus.underflow_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_out_buffer.md
PIPE_OUT_BUFFER -- requirements
Module: pipe_out_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 512; FIFO depth in 32-bit words, power of two, min 16.
REQ-002 SHALL have parameter BLOCK_WORDS, default 256; words that must be buffered before ep_blockstrobe_ready asserts, 1..DEPTH.
REQ-003 SHALL have parameter FILL_WORD, default 32'hFFFF_FFFF; word returned on a read while the FIFO is empty.
REQ-004 okClk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 din  in  32  write word from user logic.
REQ-007 din_valid  in  1  din is offered this cycle.
REQ-008 din_ready  out  1  buffer accepts din this cycle.
REQ-009 ep_read  in  1  pipe endpoint consumes ep_datain this cycle.
REQ-010 ep_datain  out  32  head word, or FILL_WORD when empty.
REQ-011 ep_blockstrobe_ready  out  1  level >= BLOCK_WORDS.
REQ-012 level  out  log2(DEPTH)+1  words currently stored.
REQ-013 underflow  out  1  sticky flag: ep_read seen while empty.
REQ-014 underflow_count  out  16  number of empty reads, saturating.

Function
REQ-015 Push SHALL occur on a cycle with din_valid && din_ready; din SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-016 din_ready SHALL equal (level != DEPTH), combinational from registered level; din_valid while full SHALL be ignored with no state change.
REQ-017 ep_datain SHALL be mem[rd_ptr] (first-word-fall-through, zero latency) when level != 0, else FILL_WORD.
REQ-018 Pop SHALL occur on a cycle with ep_read && level != 0; rd_ptr SHALL increment modulo DEPTH, and the next word SHALL appear on ep_datain in the following cycle.
REQ-019 Simultaneous push and pop SHALL leave level unchanged; push SHALL update level +1 and pop -1, registered.
REQ-020 Push with pop-attempt while empty: word SHALL be stored, pop SHALL NOT occur, ep_datain SHALL be FILL_WORD that cycle, level SHALL become 1, and the read SHALL count as underflow.
REQ-021 Pop while full with din_valid: pop SHALL occur, push SHALL NOT (din_ready was 0), and level SHALL become DEPTH-1.
REQ-022 ep_read while level == 0 SHALL set underflow and increment underflow_count, saturating at 16'hFFFF.
REQ-023 ep_blockstrobe_ready SHALL be registered, equal to (level >= BLOCK_WORDS) one cycle after level settles.
REQ-024 Pointers SHALL be log2(DEPTH) bits wide with natural wrap; full/empty SHALL be derived from level only.

Reset
REQ-025 On reset, wr_ptr, rd_ptr, level, underflow and underflow_count SHALL all be 0, and ep_blockstrobe_ready SHALL be 0.
REQ-026 While reset is high, outputs SHALL be din_ready=1 (level 0) and ep_datain=FILL_WORD; memory contents SHALL NOT be cleared.
REQ-027 Reset asserted mid-stream SHALL discard all buffered words, and the first push after deassertion SHALL be the next head.

Structure
REQ-028 FILL_WORD default, 32-bit data width and 16-bit underflow-counter width SHALL live in shared package pipe_out_pkg.
REQ-029 Storage SHALL be one sub-module pipe_out_mem: DEPTH x 32 RAM, synchronous write, asynchronous read (distributed RAM); control stays in pipe_out_buffer.

Verification
REQ-030 After reset, push 0x1..0x4 then ep_read x4 -> ep_datain shows 1,2,3,4 on successive read cycles, then FILL_WORD; level ends at 0; underflow=0.
REQ-031 Push DEPTH words with din_valid held high -> din_ready drops after word DEPTH; extra word not stored; level=DEPTH.
REQ-032 Full FIFO, assert din_valid and ep_read together -> one pop only; next cycle level=DEPTH-1 and din_ready=1.
REQ-033 Empty FIFO, ep_read x3 -> ep_datain=FFFF_FFFF; underflow=1; underflow_count=3; level stays 0.
REQ-034 BLOCK_WORDS=256: push 255 words -> ep_blockstrobe_ready=0; push word 256 -> ep_blockstrobe_ready=1 one cycle later; one pop -> returns to 0.
REQ-035 Push 10 words, pulse reset one cycle, push 0xAB -> level=1, ep_datain=0xAB, underflow_count=0.
